regfile_arbiter: RTL and testbench

- Two-requester round-robin arbiter and sequencer for the shared 16x8 register file (Register16_8).
- Lets two datapath controllers (e.g. a min/sum scan engine and a loader) share the single file.
- Each access is a single read or write using a req/done handshake.
- Sits between the requesters and the register file ports; it does not instantiate the register file.

---
 rtl/regfile_arb_pkg.sv | 17 +
 rtl/regfile_arbiter_rr_pick2.sv | 21 ++
 rtl/regfile_arbiter.sv | 123 ++++++++++++
 tb/tb_regfile_arbiter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_arb_pkg.sv
// rtl/regfile_arb_pkg.sv - state encoding, default widths and requester indices for the register-file arbiter
package regfile_arb_pkg;

    localparam int ARB_DATA_W = 8;
    localparam int ARB_ADDR_W = 4;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } arb_state_t;

endpackage

// File: rtl/regfile_arbiter_rr_pick2.sv
// rtl/regfile_arbiter_rr_pick2.sv - combinational two-way round-robin picker
module rr_pick2
    import regfile_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] pick,
    output logic       valid
);

    // On a tie the requester that did not go last wins.
    always_comb begin
        pick = req;
        if (req == 2'b11) begin
            pick = (last == REQ1) ? 2'b01 : 2'b10;
        end
    end

    assign valid = |req;

endmodule

// File: rtl/regfile_arbiter.sv
// rtl/regfile_arbiter.sv - two-requester round-robin sequencer for the shared 16x8 register file
// Optional burst locking is built when REGFILE_ARB_LOCK_EN is defined.
module regfile_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int DATA_W = ARB_DATA_W,
    parameter int ADDR_W = ARB_ADDR_W
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
`ifdef REGFILE_ARB_LOCK_EN
    input  logic              lock0,
    input  logic              lock1,
`endif
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] rf_raddr,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic              rf_ren,
    output logic              rf_wen,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic [DATA_W-1:0] rf_rdata
);

    arb_state_t        state_q;
    arb_state_t        state_d;
    logic              owner_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [1:0]        gnt_q;
    logic              last_q;
    logic [DATA_W-1:0] rdata_q;

    logic [1:0]        pick;
    logic              pick_valid;
    logic              relock;
    logic              load;
    logic              src;
    logic [1:0]        gnt_next;

    rr_pick2 u_pick (
        .req   ({req1, req0}),
        .last  (last_q),
        .pick  (pick),
        .valid (pick_valid)
    );

`ifdef REGFILE_ARB_LOCK_EN
    assign relock = (owner_q == REQ1) ? (lock1 & req1) : (lock0 & req0);
`else
    assign relock = 1'b0;
`endif

    // A locked owner reloads straight from RESP, skipping arbitration.
    assign load     = ((state_q == IDLE) && pick_valid) || ((state_q == RESP) && relock);
    assign src      = (state_q == IDLE) ? pick[1] : owner_q;
    assign gnt_next = (state_q == IDLE) ? pick : gnt_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_valid) state_d = ISSUE;
            ISSUE:   state_d = we_q ? RESP : CAPTURE;
            CAPTURE: state_d = RESP;
            RESP:    state_d = relock ? ISSUE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= IDLE;
            owner_q <= REQ0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            gnt_q   <= '0;
            last_q  <= REQ1;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                owner_q <= src;
                we_q    <= (src == REQ1) ? we1 : we0;
                addr_q  <= (src == REQ1) ? addr1 : addr0;
                wdata_q <= (src == REQ1) ? wdata1 : wdata0;
                gnt_q   <= gnt_next;
            end else if (state_q == RESP) begin
                gnt_q <= '0;
            end
            if ((state_q == IDLE) && pick_valid) begin
                last_q <= pick[1];
            end
            if (state_q == CAPTURE) begin
                rdata_q <= rf_rdata;
            end
        end
    end

    assign gnt0     = gnt_q[0];
    assign gnt1     = gnt_q[1];
    assign done0    = (state_q == RESP) && (owner_q == REQ0);
    assign done1    = (state_q == RESP) && (owner_q == REQ1);
    assign rdata    = rdata_q;
    assign rf_raddr = addr_q;
    assign rf_waddr = addr_q;
    assign rf_wdata = wdata_q;
    assign rf_wen   = (state_q == ISSUE) && we_q;
    assign rf_ren   = (state_q == ISSUE) && !we_q;

endmodule

// File: tb/tb_regfile_arbiter.sv
// tb/tb_regfile_arbiter.sv - directed table-driven bench for regfile_arbiter with a register-file model
module tb_regfile_arbiter;

    logic       Clk = 1'b0;
    logic       Rst = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [3:0] addr0 = '0, addr1 = '0;
    logic [7:0] wdata0 = '0, wdata1 = '0;
`ifdef REGFILE_ARB_LOCK_EN
    logic       lock0 = 1'b0, lock1 = 1'b0;
`endif
    logic       gnt0, gnt1, done0, done1, rf_ren, rf_wen;
    logic [7:0] rdata, rf_wdata;
    logic [3:0] rf_raddr, rf_waddr;
    logic [7:0] rf_rdata = 8'h00;
    logic [7:0] mem [16] = '{default: 8'h00};

    int tests = 0;
    int fails = 0;
    int viol  = 0;
    int cyc   = 0;
    int done_log[$];
    int wen_cyc[$];

    regfile_arbiter dut (
        .Clk(Clk), .Rst(Rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
`ifdef REGFILE_ARB_LOCK_EN
        .lock0(lock0), .lock1(lock1),
`endif
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .rdata(rdata), .rf_raddr(rf_raddr), .rf_waddr(rf_waddr),
        .rf_ren(rf_ren), .rf_wen(rf_wen), .rf_wdata(rf_wdata), .rf_rdata(rf_rdata)
    );

    always #5 Clk = ~Clk;

    // Register-file model: synchronous write, registered read.
    always @(posedge Clk) begin
        cyc <= cyc + 1;
        if (rf_wen) mem[rf_waddr] <= rf_wdata;
        if (rf_ren) rf_rdata <= mem[rf_raddr];
    end

    always @(negedge Clk) begin
        if (Rst) begin
            if (gnt0 && gnt1) viol++;
            if (rf_ren && rf_wen) viol++;
            if (done0 || done1) done_log.push_back(done1 ? 1 : 0);
            if (rf_wen) wen_cyc.push_back(cyc);
        end
    end

    typedef struct {
        logic       r0, r1, w0, w1;
        logic [3:0] a0, a1;
        logic [7:0] d0, d1;
        logic       win, exp_we;
        logic [3:0] exp_addr;
        logic [7:0] exp_wd;
        logic [3:0] exp_lat;
        logic [7:0] exp_rd;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int         got, lat;
        logic       saw_wen, saw_ren;
        logic [3:0] adr;
        logic [7:0] wd, rd;
        got = -1; lat = 0; saw_wen = 0; saw_ren = 0; adr = '0; wd = '0; rd = '0;
        @(negedge Clk);
        req0 = v.r0; we0 = v.w0; addr0 = v.a0; wdata0 = v.d0;
        req1 = v.r1; we1 = v.w1; addr1 = v.a1; wdata1 = v.d1;
        for (int n = 1; n <= 12 && got < 0; n++) begin
            @(posedge Clk);
            @(negedge Clk);
            if (n == 1) check("grant", {30'd0, gnt1, gnt0}, v.win ? 32'd2 : 32'd1);
            if (rf_wen) begin saw_wen = 1; adr = rf_waddr; wd = rf_wdata; end
            if (rf_ren) begin saw_ren = 1; adr = rf_raddr; end
            if (done0 || done1) begin got = done1 ? 1 : 0; lat = n + 1; rd = rdata; end
        end
        req0 = 0; req1 = 0;
        check("winner", got, {31'd0, v.win});
        check("latency", lat, {28'd0, v.exp_lat});
        check("wen_seen", {31'd0, saw_wen}, {31'd0, v.exp_we});
        check("ren_seen", {31'd0, saw_ren}, {31'd0, !v.exp_we});
        check("rf_addr", {28'd0, adr}, {28'd0, v.exp_addr});
        if (v.exp_we) check("rf_wdata", {24'd0, wd}, {24'd0, v.exp_wd});
        check("rdata", {24'd0, rd}, {24'd0, v.exp_rd});
        @(negedge Clk);
        check("done_one_cycle", {30'd0, done1, done0}, 32'd0);
    endtask

    initial begin
        int order[$];
        int k;
        logic seen;
        vecs[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'h3, 4'h0, 8'hA5, 8'h00, 1'b0, 1'b1, 4'h3, 8'hA5, 4'd3, 8'h00};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h3, 8'h00, 8'h00, 1'b1, 1'b0, 4'h3, 8'h00, 4'd4, 8'hA5};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 4'h5, 4'h6, 8'h3C, 8'hC3, 1'b0, 1'b1, 4'h5, 8'h3C, 4'd3, 8'hA5};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'h5, 4'h3, 8'h00, 8'h00, 1'b1, 1'b0, 4'h3, 8'h00, 4'd4, 8'hA5};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'h0, 4'h9, 8'h00, 8'h5A, 1'b1, 1'b1, 4'h9, 8'h5A, 4'd3, 8'hA5};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 4'h9, 4'h0, 8'h00, 8'hFF, 1'b0, 1'b0, 4'h9, 8'h00, 4'd4, 8'h5A};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h5, 4'h0, 8'h00, 8'h00, 1'b0, 1'b0, 4'h5, 8'h00, 4'd4, 8'h3C};
        vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 4'hF, 4'h9, 8'h11, 8'h00, 1'b1, 1'b0, 4'h9, 8'h00, 4'd4, 8'h5A};
        vecs[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'h3, 4'h5, 8'h00, 8'h00, 1'b0, 1'b0, 4'h3, 8'h00, 4'd4, 8'hA5};

        repeat (2) @(posedge Clk);
        @(negedge Clk);
        check("reset_outputs", {gnt0, gnt1, done0, done1, rf_ren, rf_wen, rdata, rf_raddr, rf_waddr, rf_wdata}, 32'd0);
        Rst = 1'b1;
        @(negedge Clk);

        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        // req0 drops right after its grant; the write must still land.
        @(negedge Clk);
        req0 = 1; we0 = 1; addr0 = 4'h7; wdata0 = 8'h77;
        @(posedge Clk);
        @(negedge Clk);
        req0 = 0;
        seen = 0;
        for (int n = 0; n < 8 && !seen; n++) begin
            @(negedge Clk);
            if (done0) seen = 1;
        end
        check("drop_done0", {31'd0, seen}, 32'd1);
        check("drop_write", {24'd0, mem[7]}, 32'h77);
        repeat (3) @(negedge Clk);
        check("drop_idle_gnt", {30'd0, gnt1, gnt0}, 32'd0);

        // Asynchronous reset while a read sits in CAPTURE.
        done_log.delete();
        @(negedge Clk);
        req1 = 1; we1 = 0; addr1 = 4'h5;
        @(posedge Clk);
        @(posedge Clk);
        @(negedge Clk);
        Rst = 1'b0;
        #1;
        check("async_reset", {gnt0, gnt1, done0, done1, rf_ren, rf_wen, rdata, rf_raddr, rf_waddr, rf_wdata}, 32'd0);
        req1 = 0;
        @(negedge Clk);
        Rst = 1'b1;
        repeat (3) @(negedge Clk);
        check("no_done_after_reset", done_log.size(), 32'd0);

        // Both held continuously: grants alternate starting with requester 0.
        req0 = 1; we0 = 1; addr0 = 4'h1; wdata0 = 8'h21;
        req1 = 1; we1 = 1; addr1 = 4'h2; wdata1 = 8'h42;
        @(posedge Clk);
        @(negedge Clk);
        check("fair_first_gnt", {30'd0, gnt1, gnt0}, 32'd1);
        for (int n = 0; n < 40 && order.size() < 4; n++) begin
            if (done0) order.push_back(0);
            if (done1) order.push_back(1);
            if (order.size() < 4) @(negedge Clk);
        end
        req0 = 0; req1 = 0;
        check("fair_count", order.size(), 32'd4);
        for (int i = 0; i < 4 && i < order.size(); i++) check("fair_order", order[i], i % 2);
        check("fair_mem", {16'd0, mem[1], mem[2]}, 32'h2142);
        repeat (2) @(negedge Clk);

`ifdef REGFILE_ARB_LOCK_EN
        // Locked write burst from requester 0 holds requester 1 off.
        done_log.delete();
        wen_cyc.delete();
        req0 = 1; lock0 = 1; we0 = 1; addr0 = 4'h0; wdata0 = 8'h10;
        @(posedge Clk);
        @(negedge Clk);
        req1 = 1; we1 = 0; addr1 = 4'h2;
        k = 0;
        seen = 0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(posedge Clk);
            @(negedge Clk);
            if (done0) begin
                k++;
                if (k < 4) begin addr0 = k[3:0]; wdata0 = 8'h10 + k[7:0]; end
                else begin req0 = 0; lock0 = 0; end
            end
            if (done1) begin
                seen = 1;
                req1 = 0;
                check("lock_rdata", {24'd0, rdata}, 32'h12);
            end
        end
        check("lock_req1_done", {31'd0, seen}, 32'd1);
        check("lock_wen_count", wen_cyc.size(), 32'd4);
        for (int i = 1; i < 4 && i < wen_cyc.size(); i++) check("lock_wen_spacing", wen_cyc[i] - wen_cyc[i-1], 32'd2);
        check("lock_order", done_log.size() == 5 && done_log[3] == 0 && done_log[4] == 1, 32'd1);
        check("lock_mem", {mem[0], mem[1], mem[2], mem[3]}, 32'h10111213);
        repeat (2) @(negedge Clk);
`endif

        check("invariants", viol, 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
